// File: rtl/izh_neuron_scheduler.sv
// Time-multiplexed Izhikevich neuron controller: per-neuron state/config bank,
// sweep FSM driving one shared datapath over req/ack, and a spike event FIFO.
module izh_neuron_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int IDX_W      = 2,
  parameter int W          = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 clear,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [3:0]           cfg_a,
  input  logic [3:0]           cfg_b,
  input  logic [7:0]           cfg_i,
  input  logic                 cfg_en,
  output logic                 dp_req,
  output logic [W-1:0]         dp_v,
  output logic [W-1:0]         dp_u,
  output logic [3:0]           dp_a,
  output logic [3:0]           dp_b,
  output logic [W-1:0]         dp_i,
  input  logic                 dp_ack,
  input  logic [W-1:0]         dp_v_next,
  input  logic [W-1:0]         dp_u_next,
  input  logic                 dp_spike,
  output logic                 spike_valid,
  output logic [8+IDX_W-1:0]   spike_data,
  input  logic                 spike_ready,
  output logic                 busy,
  output logic                 sweep_done,
  output logic                 overrun,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [W-1:0]         rd_v
);

  localparam int          FP_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [W-1:0] V_RST = W'(18'h3_4CCD);
  localparam logic [W-1:0] U_RST = W'(18'h3_CCCD);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WB, S_FINISH} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0]           r_v   [N_NEURONS];
  logic [W-1:0]           r_u   [N_NEURONS];
  logic [3:0]             r_a   [N_NEURONS];
  logic [3:0]             r_b   [N_NEURONS];
  logic [7:0]             r_i   [N_NEURONS];
  logic [N_NEURONS-1:0]   r_en;

  logic [IDX_W-1:0]       r_ptr;
  logic [7:0]             r_tick_cnt;
  logic                   r_overrun;
  logic [W-1:0]           r_op_v, r_op_u, r_op_i;
  logic [3:0]             r_op_a, r_op_b;
  logic [W-1:0]           r_res_v, r_res_u;
  logic                   r_res_spike;
  logic [W-1:0]           r_rd_v;

  logic [8+IDX_W-1:0]     r_fifo [FIFO_DEPTH];
  logic [FP_W-1:0]        r_wr_ptr, r_rd_ptr;
  logic [FP_W:0]          r_count;

  logic w_tick_accept, w_clear, w_last, w_fifo_full;
  logic w_wb_stall, w_wb_commit, w_push, w_pop, w_skip;

  assign w_tick_accept = (r_state == S_IDLE) && tick && !clear;
  assign w_clear       = (r_state == S_IDLE) && clear;
  assign w_last        = (r_ptr == IDX_W'(N_NEURONS - 1));
  assign w_fifo_full   = (r_count == (FP_W+1)'(FIFO_DEPTH));
  assign w_skip        = (r_state == S_LOAD) && !r_en[r_ptr];
  // Fullness is judged before this cycle's pop, so a stalled push lands one cycle after the pop.
  assign w_wb_stall    = (r_state == S_WB) && r_res_spike && w_fifo_full;
  assign w_wb_commit   = (r_state == S_WB) && !w_wb_stall;
  assign w_push        = w_wb_commit && r_res_spike;
  assign w_pop         = spike_valid && spike_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_tick_accept) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (r_en[r_ptr]) w_state_nxt = S_ISSUE;
        else if (w_last) w_state_nxt = S_FINISH;
      end
      S_ISSUE:  if (dp_ack) w_state_nxt = S_WB;
      S_WB:     if (!w_wb_stall) w_state_nxt = w_last ? S_FINISH : S_LOAD;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dp_req     = (r_state == S_ISSUE);
    busy       = (r_state != S_IDLE);
    sweep_done = (r_state == S_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_tick_cnt <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_tick_accept) begin
        r_ptr      <= '0;
        r_tick_cnt <= r_tick_cnt + 8'd1;
      end else if ((w_skip || w_wb_commit) && !w_last) begin
        r_ptr <= r_ptr + IDX_W'(1);
      end
      if (tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_NEURONS; k++) begin
        r_v[k] <= V_RST;
        r_u[k] <= U_RST;
      end
    end else if (w_clear) begin
      for (int unsigned k = 0; k < N_NEURONS; k++) begin
        r_v[k] <= V_RST;
        r_u[k] <= U_RST;
      end
    end else if (w_wb_commit) begin
      r_v[r_ptr] <= r_res_v;
      r_u[r_ptr] <= r_res_u;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_NEURONS; k++) begin
        r_a[k] <= 4'd1;
        r_b[k] <= 4'd2;
        r_i[k] <= 8'd0;
      end
      r_en <= '1;
    end else if (cfg_we) begin
      r_a[cfg_idx]  <= cfg_a;
      r_b[cfg_idx]  <= cfg_b;
      r_i[cfg_idx]  <= cfg_i;
      r_en[cfg_idx] <= cfg_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_v      <= '0;
      r_op_u      <= '0;
      r_op_i      <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_res_v     <= '0;
      r_res_u     <= '0;
      r_res_spike <= 1'b0;
      r_rd_v      <= '0;
    end else begin
      if ((r_state == S_LOAD) && r_en[r_ptr]) begin
        r_op_v <= r_v[r_ptr];
        r_op_u <= r_u[r_ptr];
        r_op_a <= r_a[r_ptr];
        r_op_b <= r_b[r_ptr];
        r_op_i <= W'({r_i[r_ptr], 10'b0});
      end
      if ((r_state == S_ISSUE) && dp_ack) begin
        r_res_v     <= dp_v_next;
        r_res_u     <= dp_u_next;
        r_res_spike <= dp_spike;
      end
      r_rd_v <= r_v[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) r_fifo[k] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= {r_tick_cnt, r_ptr};
        r_wr_ptr         <= r_wr_ptr + FP_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + FP_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FP_W+1)'(1);
        2'b01:   r_count <= r_count - (FP_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dp_v        = r_op_v;
  assign dp_u        = r_op_u;
  assign dp_a        = r_op_a;
  assign dp_b        = r_op_b;
  assign dp_i        = r_op_i;
  assign spike_valid = (r_count != '0);
  assign spike_data  = r_fifo[r_rd_ptr];
  assign overrun     = r_overrun;
  assign rd_v        = r_rd_v;

endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Bench for izh_neuron_scheduler: datapath stub, spike consumer, and a per-sweep
// reference model of neuron state and expected spike events.
module tb_izh_neuron_scheduler;

  localparam logic [17:0] V_RST = 18'h3_4CCD;
  localparam logic [17:0] U_RST = 18'h3_CCCD;

  logic        clk, rst_n, tick, clear, cfg_we, cfg_en;
  logic [1:0]  cfg_idx, rd_idx;
  logic [3:0]  cfg_a, cfg_b, dp_a, dp_b;
  logic [7:0]  cfg_i;
  logic        dp_req, dp_ack, dp_spike, spike_valid, spike_ready;
  logic        busy, sweep_done, overrun;
  logic [17:0] dp_v, dp_u, dp_i, dp_v_next, dp_u_next, rd_v;
  logic [9:0]  spike_data;

  izh_neuron_scheduler #(.N_NEURONS(4), .IDX_W(2), .W(18), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .clear(clear),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_a(cfg_a), .cfg_b(cfg_b),
    .cfg_i(cfg_i), .cfg_en(cfg_en),
    .dp_req(dp_req), .dp_v(dp_v), .dp_u(dp_u), .dp_a(dp_a), .dp_b(dp_b), .dp_i(dp_i),
    .dp_ack(dp_ack), .dp_v_next(dp_v_next), .dp_u_next(dp_u_next), .dp_spike(dp_spike),
    .spike_valid(spike_valid), .spike_data(spike_data), .spike_ready(spike_ready),
    .busy(busy), .sweep_done(sweep_done), .overrun(overrun),
    .rd_idx(rd_idx), .rd_v(rd_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int stub_wait = 0;
  bit stub_noise = 0;
  int n_acks = 0;
  bit pop_en = 0;
  bit pop_force = 0;
  int n_pops = 0;

  logic [17:0] m_v [4];
  logic [17:0] m_u [4];
  logic [3:0]  m_a [4];
  logic [3:0]  m_b [4];
  logic [7:0]  m_i [4];
  bit          m_en [4];
  logic [7:0]  m_tick;
  logic [9:0]  exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: one sweep's effect on state and the spike events it must produce, in order.
  function automatic void model_sweep();
    logic [17:0] u_old;
    m_tick = m_tick + 8'd1;
    for (int n = 0; n < 4; n++) begin
      if (m_en[n]) begin
        u_old = m_u[n];
        if (m_i[n][0]) begin
          m_v[n] = u_old;
          exp_q.push_back({m_tick, 2'(n)});
        end else begin
          m_v[n] = m_v[n] + 18'd1 + 18'(m_b[n]) + 18'(u_old[1:0]);
        end
        m_u[n] = u_old + 18'(m_a[n]) + {m_i[n], 10'b0};
      end
    end
  endfunction

  function automatic void model_clear();
    for (int n = 0; n < 4; n++) begin
      m_v[n] = V_RST;
      m_u[n] = U_RST;
    end
  endfunction

  // Datapath stub: spike when stimulus bit 0 is set; spiking neurons take v from u.
  initial begin
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      if (dp_req) begin
        if (w >= stub_wait) begin
          dp_ack    = 1'b1;
          dp_spike  = dp_i[10];
          dp_v_next = dp_i[10] ? dp_u : dp_v + 18'd1 + 18'(dp_b) + 18'(dp_u[1:0]);
          dp_u_next = dp_u + 18'(dp_a) + dp_i;
          n_acks++;
          w = 0;
        end else begin
          dp_ack = 1'b0;
          w++;
        end
      end else begin
        w = 0;
        if (stub_noise && ($urandom_range(0, 1) == 1)) begin
          dp_ack    = 1'b1;
          dp_spike  = 1'b1;
          dp_v_next = 18'($urandom);
          dp_u_next = 18'($urandom);
        end else begin
          dp_ack   = 1'b0;
          dp_spike = 1'b0;
        end
      end
    end
  end

  // Spike consumer: each accepted pop must match the head of the expected event queue.
  initial begin
    logic r;
    forever begin
      @(negedge clk);
      #1;
      r = pop_en ? 1'($urandom_range(0, 1)) : pop_force;
      spike_ready = r;
      if (r && spike_valid) begin
        n_pops++;
        if (exp_q.size() == 0) chk("pop_unexpected", 32'(spike_data), 32'h3ff);
        else                   chk("spike_data", 32'(spike_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cfg_write(input int n, input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] i, input bit en);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'(n); cfg_a = a; cfg_b = b; cfg_i = i; cfg_en = en;
    @(negedge clk);
    cfg_we = 1'b0;
    m_a[n] = a; m_b[n] = b; m_i[n] = i; m_en[n] = en;
  endtask

  task automatic check_all_v();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      rd_idx = 2'(n);
      @(negedge clk);
      chk($sformatf("rd_v[%0d]", n), 32'(rd_v), 32'(m_v[n]));
    end
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (busy && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_sweep(input int exp_len, input int exp_acks);
    int len, dn;
    n_acks = 0;
    @(negedge clk);
    tick = 1'b1;
    model_sweep();
    @(negedge clk);
    tick = 1'b0;
    len = 0; dn = 0;
    while (busy && len < 3000) begin
      len++;
      if (sweep_done) dn++;
      @(negedge clk);
    end
    chk("sweep_timeout", 32'(busy), 32'd0);
    if (exp_len >= 0)  chk("sweep_len", 32'(len), 32'(exp_len));
    chk("sweep_done_cnt", 32'(dn), 32'd1);
    if (exp_acks >= 0) chk("dp_req_cnt", 32'(n_acks), 32'(exp_acks));
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    repeat (3) @(negedge clk);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("fifo_empty", 32'(spike_valid), 32'd0);
  endtask

  initial begin
    logic [17:0] old_v0;
    rst_n = 1'b0; tick = 1'b0; clear = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_a = '0; cfg_b = '0; cfg_i = '0; cfg_en = 1'b0; rd_idx = '0;
    dp_ack = 1'b0; dp_spike = 1'b0; dp_v_next = '0; dp_u_next = '0; spike_ready = 1'b0;
    m_tick = 8'd0;
    model_clear();
    for (int n = 0; n < 4; n++) begin
      m_a[n] = 4'd1; m_b[n] = 4'd2; m_i[n] = 8'd0; m_en[n] = 1'b1;
    end

    #22;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_spike_valid", 32'(spike_valid), 32'd0);
    chk("rst_rd_v", 32'(rd_v), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_dp_req", 32'(dp_req), 32'd0);
    chk("rst_spike_data", 32'(spike_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_all_v();

    // Two-wait-cycle datapath, spikes on neurons 1 and 3.
    cfg_write(1, 4'd1, 4'd2, 8'h01, 1'b1);
    cfg_write(3, 4'd1, 4'd2, 8'h03, 1'b1);
    stub_wait = 2;
    run_sweep(21, 4);
    check_all_v();
    chk("spike_head", 32'(spike_data), 32'({8'd1, 2'd1}));
    chk("spike_valid_hold", 32'(spike_valid), 32'd1);
    pop_en = 1;
    drain();

    // Neuron 2 disabled, zero-wait ack, spurious acks outside ISSUE.
    cfg_write(2, 4'd3, 4'd1, 8'h00, 1'b0);
    stub_wait = 0;
    stub_noise = 1;
    run_sweep(11, 3);
    check_all_v();
    drain();

    // FIFO full: second sweep must stall in WB until space is freed.
    pop_en = 0;
    stub_noise = 0;
    for (int n = 0; n < 4; n++) cfg_write(n, 4'(n + 1), 4'd1, 8'(2 * n + 1), 1'b1);
    run_sweep(13, 4);
    chk("fifo_full_valid", 32'(spike_valid), 32'd1);
    old_v0 = m_v[0];
    n_pops = 0;
    rd_idx = 2'd0;
    @(negedge clk);
    tick = 1'b1;
    model_sweep();
    @(negedge clk);
    tick = 1'b0;
    repeat (20) @(negedge clk);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_no_req", 32'(dp_req), 32'd0);
    chk("stall_no_write", 32'(rd_v), 32'(old_v0));
    pop_force = 1;
    @(negedge clk);
    pop_force = 0;
    repeat (4) @(negedge clk);
    chk("stall_released_write", 32'(rd_v), 32'(m_v[0]));
    chk("stall_next_busy", 32'(busy), 32'd1);
    pop_en = 1;
    wait_idle();
    drain();
    chk("no_event_lost", 32'(n_pops), 32'd8);
    check_all_v();

    // Simultaneous tick and clear in IDLE: clear wins, tick dropped silently.
    @(negedge clk);
    tick = 1'b1; clear = 1'b1;
    @(negedge clk);
    tick = 1'b0; clear = 1'b0;
    model_clear();
    chk("tc_busy", 32'(busy), 32'd0);
    chk("tc_overrun", 32'(overrun), 32'd0);
    check_all_v();

    // Overrun and ignored clear during a sweep.
    for (int n = 0; n < 4; n++) cfg_write(n, 4'd2, 4'd3, (n == 2) ? 8'h05 : 8'h00, 1'b1);
    stub_wait = 2;
    @(negedge clk);
    tick = 1'b1;
    model_sweep();
    @(negedge clk);
    tick = 1'b0;
    repeat (5) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    chk("overrun_set", 32'(overrun), 32'd1);
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_idle();
    chk("overrun_sticky", 32'(overrun), 32'd1);
    check_all_v();
    drain();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    check_all_v();

    // Randomized configurations, wait states, spurious acks and pop timing.
    for (int it = 0; it < 8; it++) begin
      for (int n = 0; n < 4; n++)
        cfg_write(n, 4'($urandom), 4'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      stub_wait  = $urandom_range(0, 3);
      stub_noise = 1'($urandom_range(0, 1));
      run_sweep(-1, -1);
      check_all_v();
      drain();
    end
    chk("final_overrun", 32'(overrun), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/izh_neuron_scheduler.md
Name: izh_neuron_scheduler

Overview:
Time-multiplexes one Izhikevich update datapath across N_NEURONS virtual neurons. Holds per-neuron state (v, u) and configuration (a, b shift amounts, 8-bit stimulus I, enable). On each tick, sweeps all enabled neurons through the datapath over a req/ack handshake and writes back the results. Queues spike events in a FIFO for the output/pin-mux logic.

Parameters:
N_NEURONS, 4, number of virtual neurons (power of 2, 2..16)
IDX_W, 2, log2(N_NEURONS)
W, 18, state width, signed 2.16 two's complement
FIFO_DEPTH, 4, spike event FIFO entries (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  single-cycle pulse requesting one update sweep
clear  in  1  reload all neuron state to reset values (honoured only in IDLE)
cfg_we  in  1  config write strobe
cfg_idx  in  IDX_W  neuron being configured
cfg_a  in  4  u-decay shift amount a
cfg_b  in  4  v-coupling shift amount b
cfg_i  in  8  stimulus; datapath I = {cfg_i, 10'b0}
cfg_en  in  1  neuron enable
dp_req  out  1  operands valid to datapath
dp_v, dp_u  out  W  current state operands
dp_a, dp_b  out  4  shift operands
dp_i  out  W  stimulus operand
dp_ack  in  1  datapath result valid
dp_v_next, dp_u_next  in  W  updated state (already reset-substituted on spike)
dp_spike  in  1  v exceeded threshold this step
spike_valid  out  1  FIFO non-empty
spike_data  out  8+IDX_W  {tick_cnt[7:0], neuron idx}
spike_ready  in  1  consumer pop
busy  out  1  sweep in progress
sweep_done  out  1  one-cycle pulse at sweep end
overrun  out  1  sticky: tick arrived while busy
rd_idx  in  IDX_W  state readback select
rd_v  out  W  registered v[rd_idx], 1-cycle latency

Behaviour:
- Reset (async assert, sync release): all v = 18'sh3_4CCD (-0.7), u = 18'sh3_CCCD (-0.2), a = 1, b = 2, I = 0, en = 1. FSM = IDLE. tick_cnt = 0, FIFO empty. All outputs 0 (rd_v = 0).
- FSM: IDLE -> LOAD on tick. tick_cnt increments on accept (8-bit wrap). ptr = 0.
- LOAD: if en[ptr], register operands from bank, go to ISSUE. Else the neuron is skipped (1 cycle): ptr++ or FINISH if ptr = N-1.
- ISSUE: dp_req = 1 with operands stable until dp_ack is sampled high. Capture results in that cycle, go to WB. dp_req falls the next cycle. dp_ack while dp_req = 0 is ignored.
- WB: write v_next/u_next to bank[ptr].
  - If dp_spike and FIFO full: stall in WB, no write, until space is available. Write and push then occur in the same cycle.
  - Then ptr++ -> LOAD, or FINISH when ptr = N-1.
- FINISH: sweep_done = 1 for one cycle, -> IDLE.
- busy = 1 in every state except IDLE.
- Latency with zero-wait ack: 3 cycles per enabled neuron, 1 per disabled, +1 for FINISH. For N = 4 all enabled: tick at cycle 0 -> sweep_done at cycle 13.
- tick while busy: ignored and overrun set. Only reset clears overrun. A tick in the same cycle as FINISH also counts as overrun.
- clear in IDLE: state reloaded next cycle; config untouched. A simultaneous tick and clear in IDLE applies clear and ignores tick (no overrun). clear while busy is ignored.
- Config writes: accepted in any state, take effect at the next LOAD of that neuron. Operands already latched for the in-flight neuron are unaffected.
- FIFO: push in WB and pop (spike_valid & spike_ready) in the same cycle are both performed. A push into a full FIFO only happens via the stall rule, so there is no drop. spike_data is valid whenever spike_valid = 1.
- Arithmetic: the controller does no arithmetic on state; it stores and forwards W-bit values exactly.

Test Plan:
- Reset then rd_idx = 0..3 -> rd_v = 18'sh3_4CCD for each; spike_valid = 0, busy = 0.
- Stub datapath with ack after 2 wait cycles, returning v+1, u+1. One tick -> each neuron's v incremented by 1; busy for 4*5+1 = 21 cycles; one sweep_done pulse.
- cfg_en[2] = 0, then tick -> neuron 2 unchanged; dp_req asserted exactly 3 times; sweep length 3*3+1+1 = 11 cycles with zero-wait ack.
- Stub asserts dp_spike for neurons 1 and 3 on tick #1 -> FIFO holds {8'd1, 2'd1} then {8'd1, 2'd3}, popped in order.
- spike_ready = 0, spike on every neuron for 2 ticks -> FIFO fills at 4. Fifth spike stalls WB (busy held, bank[ptr] not written) until one pop, then completes with no event lost.
- tick pulsed mid-sweep -> overrun = 1 and stays set; tick_cnt advances only once. clear during the sweep -> no effect; clear in IDLE -> all v back to 18'sh3_4CCD.
